reg_bank: RTL

- Parametrised successor to the single 8-bit write-enabled data register.
- Provides DEPTH registers, each WIDTH bits wide.
- One write port with four write modes: load, increment, decrement, clear.
- Two combinational read ports, optional write-to-read bypass, zero and carry status flags.
- Serves as the PATP core's working register set; the datapath reads operands and status from it.

---
 rtl/patp_pkg.sv | 12 +
 rtl/reg_bank_alu.sv | 36 +++
 rtl/reg_bank.sv | 86 ++++++++
 3 files changed

// File: rtl/patp_pkg.sv
// Shared definitions for the PATP core working register set.
// Holds the write-mode encoding used by reg_bank and reg_bank_alu.
package patp_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

endpackage

// File: rtl/reg_bank_alu.sv
// Combinational next-value unit for one register write.
// Ports: op (write mode), cur (current register value), wdata (load
// data) -> next (value to commit), carry_nxt (INC carry / DEC borrow),
// zero_nxt (next is all zeros). Shared by the write and bypass paths.
module reg_bank_alu
    import patp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] next,
    output logic             carry_nxt,
    output logic             zero_nxt
);

    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    always_comb begin
        next      = cur;
        carry_nxt = 1'b0;
        unique case (op)
            OP_LOAD: next = wdata;
            // Extra top bit catches the wrap: carry on INC of all ones,
            // borrow on DEC of zero.
            OP_INC:  {carry_nxt, next} = {1'b0, cur} + ONE;
            OP_DEC:  {carry_nxt, next} = {1'b0, cur} - ONE;
            OP_CLR:  next = '0;
            default: next = cur;
        endcase
    end

    assign zero_nxt = (next == '0);

endmodule

// File: rtl/reg_bank.sv
// Parametrised working register set: DEPTH x WIDTH registers with one
// write port (load/inc/dec/clr), two combinational read ports, optional
// write-to-read bypass and registered zero/carry flags.
// Ports: clk, rst (sync active-high), we, op, waddr, wdata,
// raddr_a -> rdata_a, raddr_b -> rdata_b, zero, carry.
module reg_bank
    import patp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             zero,
    output logic             carry
);

    logic [WIDTH-1:0] regs [DEPTH];

    logic             wr_ok;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] next;
    logic             carry_nxt;
    logic             zero_nxt;
    logic             byp_a;
    logic             byp_b;

    // Range checks are done at 32 bits so a non-power-of-two DEPTH
    // compares correctly against the full address range.
    assign wr_ok = we && (32'(waddr) < DEPTH);
    assign cur   = wr_ok ? regs[waddr] : '0;

    reg_bank_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .op       (op_t'(op)),
        .cur      (cur),
        .wdata    (wdata),
        .next     (next),
        .carry_nxt(carry_nxt),
        .zero_nxt (zero_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            zero  <= 1'b0;
            carry <= 1'b0;
        end else if (wr_ok) begin
            regs[waddr] <= next;
            zero        <= zero_nxt;
            carry       <= carry_nxt;
        end
    end

    // Bypass is withheld during reset so reads show the stored value.
    assign byp_a = (BYPASS != 0) && wr_ok && !rst && (raddr_a == waddr);
    assign byp_b = (BYPASS != 0) && wr_ok && !rst && (raddr_b == waddr);

    always_comb begin
        rdata_a = '0;
        if (32'(raddr_a) < DEPTH) begin
            rdata_a = byp_a ? next : regs[raddr_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (32'(raddr_b) < DEPTH) begin
            rdata_b = byp_b ? next : regs[raddr_b];
        end
    end

endmodule
